vin_bus_sched: RTL and testbench

- Cycle scheduler for the shared VIN/GEN bus (busA/busB plus strobes _sm, _st, _sg, r_wi, adr).
- Interleaves display character fetches (type 1 read followed by type 2 GEN output) with CPU mailbox transfers: type 3 write from TA/TB to page memory, type 4 read from page memory into TA/TB.
- Sits on the VIN side between the display timing generator and GEN_9341.
- Drives the strobes GEN_9341 samples and tells the CPU path when a mailbox transfer is complete.

---
 rtl/vin_bus_sched.sv | 153 +++++++++++++++
 tb/tb_vin_bus_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vin_bus_sched.sv
// vin_bus_sched: cycle scheduler for the shared VIN/GEN bus.
// Interleaves display fetch pairs (type 1 read + type 2 GEN output) with
// CPU mailbox transfers (type 3 write / type 4 read) and drives the strobes.
module vin_bus_sched #(
   parameter int unsigned T_SETUP    = 2,
   parameter int unsigned T_STROBE   = 4,
   parameter int unsigned T_HOLD     = 2,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic       clk,
   input  logic       _reset,
   input  logic       disp_req,
   input  logic [3:0] disp_slice,
   output logic       disp_ack,
   input  logic       _ve,
   input  logic       cpu_rd,
   input  logic [3:0] cpu_slice,
   output logic       cpu_done,
   output logic       _sm,
   output logic       _sg,
   output logic       _st,
   output logic       r_wi,
   output logic [3:0] adr,
   output logic [1:0] cyc_type
);

   localparam int unsigned PH_W = 8;
   localparam int unsigned SV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      SG_SETUP,
      SG_STROBE,
      SG_HOLD
   } state_t;

   state_t            state;
   logic [PH_W-1:0]   phase;
   logic [SV_W-1:0]   starve;
   logic              phase_end;
   logic              cpu_win;

   // Current phase finishes on this clock.
   assign phase_end = (phase == '0);

   // CPU takes the bus if it is alone, or if display has starved it long enough.
   assign cpu_win = !_ve && (!disp_req || (starve == SV_W'(STARVE_MAX)));

   // Sequencer: arbitration, phase counting and registered bus outputs.
   always_ff @(posedge clk) begin
      if (!_reset) begin
         state    <= IDLE;
         phase    <= '0;
         starve   <= '0;
         _sm      <= 1'b1;
         _sg      <= 1'b1;
         _st      <= 1'b1;
         r_wi     <= 1'b1;
         adr      <= 4'd0;
         cyc_type <= 2'd0;
         disp_ack <= 1'b0;
         cpu_done <= 1'b0;
      end else begin
         disp_ack <= 1'b0;
         cpu_done <= 1'b0;
         phase    <= phase - PH_W'(1);
         case (state)
            IDLE: begin
               if (cpu_win) begin
                  state    <= SETUP;
                  phase    <= PH_W'(T_SETUP - 1);
                  _st      <= 1'b0;
                  r_wi     <= cpu_rd;
                  adr      <= cpu_slice;
                  cyc_type <= {1'b1, cpu_rd};
                  starve   <= '0;
               end else begin
                  if (disp_req) begin
                     state    <= SETUP;
                     phase    <= PH_W'(T_SETUP - 1);
                     _st      <= 1'b1;
                     r_wi     <= 1'b1;
                     adr      <= disp_slice;
                     cyc_type <= 2'd1;
                  end
                  // _ve low here implies a display grant was just made.
                  if (_ve) begin
                     starve <= '0;
                  end else if (starve != SV_W'(STARVE_MAX)) begin
                     starve <= starve + SV_W'(1);
                  end
               end
            end
            SETUP: begin
               if (phase_end) begin
                  state <= STROBE;
                  phase <= PH_W'(T_STROBE - 1);
                  _sm   <= 1'b0;
               end
            end
            STROBE: begin
               if (phase_end) begin
                  state <= HOLD;
                  phase <= PH_W'(T_HOLD - 1);
                  _sm   <= 1'b1;
               end
            end
            HOLD: begin
               if (phase_end) begin
                  if (cyc_type == 2'd1) begin
                     state <= SG_SETUP;
                     phase <= PH_W'(T_SETUP - 1);
                  end else begin
                     state    <= IDLE;
                     cyc_type <= 2'd0;
                     cpu_done <= 1'b1;
                  end
               end
            end
            SG_SETUP: begin
               if (phase_end) begin
                  state <= SG_STROBE;
                  phase <= PH_W'(T_STROBE - 1);
                  _sg   <= 1'b0;
               end
            end
            SG_STROBE: begin
               if (phase_end) begin
                  state <= SG_HOLD;
                  phase <= PH_W'(T_HOLD - 1);
                  _sg   <= 1'b1;
               end
            end
            SG_HOLD: begin
               if (phase_end) begin
                  state    <= IDLE;
                  cyc_type <= 2'd0;
                  disp_ack <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               _sm   <= 1'b1;
               _sg   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vin_bus_sched.sv
// Testbench for vin_bus_sched: cycle-position reference model plus directed
// and randomized stimulus.
module tb_vin_bus_sched;

   localparam int TS   = 2;
   localparam int TT   = 4;
   localparam int TH   = 2;
   localparam int SMAX = 3;
   localparam int L    = TS + TT + TH;

   logic       clk        = 1'b0;
   logic       reset_n    = 1'b0;
   logic       disp_req   = 1'b0;
   logic [3:0] disp_slice = 4'd0;
   logic       ve_n       = 1'b1;
   logic       cpu_rd     = 1'b0;
   logic [3:0] cpu_slice  = 4'd0;
   logic       disp_ack;
   logic       cpu_done;
   logic       sm_n;
   logic       sg_n;
   logic       st_n;
   logic       r_wi;
   logic [3:0] adr;
   logic [1:0] cyc_type;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state: position k (1-based clock since grant) within a cycle.
   int m_busy = 0, m_k = 0, m_disp = 0, m_starve = 0;
   int m_adr = 0, m_st = 1, m_rw = 1, m_ct = 0, m_ack = 0, m_done = 0;

   always #5 clk = ~clk;

   vin_bus_sched dut (
      .clk        (clk),
      ._reset     (reset_n),
      .disp_req   (disp_req),
      .disp_slice (disp_slice),
      .disp_ack   (disp_ack),
      ._ve        (ve_n),
      .cpu_rd     (cpu_rd),
      .cpu_slice  (cpu_slice),
      .cpu_done   (cpu_done),
      ._sm        (sm_n),
      ._sg        (sg_n),
      ._st        (st_n),
      .r_wi       (r_wi),
      .adr        (adr),
      .cyc_type   (cyc_type)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: whole-cycle bookkeeping from the scheduling rules.
   always @(posedge clk) begin
      if (!reset_n) begin
         m_busy = 0; m_k = 0; m_disp = 0; m_starve = 0;
         m_adr = 0; m_st = 1; m_rw = 1; m_ct = 0; m_ack = 0; m_done = 0;
      end else begin
         m_ack  = 0;
         m_done = 0;
         if (m_busy != 0) begin
            if (m_k == ((m_disp != 0) ? 2 * L : L)) begin
               m_busy = 0;
               m_ct   = 0;
               if (m_disp != 0) m_ack = 1;
               else             m_done = 1;
            end else begin
               m_k++;
            end
         end else if (!ve_n && (!disp_req || m_starve == SMAX)) begin
            m_busy = 1; m_k = 1; m_disp = 0; m_starve = 0;
            m_st = 0; m_rw = int'(cpu_rd); m_adr = int'(cpu_slice); m_ct = 2 + int'(cpu_rd);
         end else begin
            if (disp_req) begin
               m_busy = 1; m_k = 1; m_disp = 1;
               m_st = 1; m_rw = 1; m_adr = int'(disp_slice); m_ct = 1;
            end
            if (ve_n)                         m_starve = 0;
            else if (disp_req && m_starve < SMAX) m_starve++;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      int e_sm, e_sg;
      e_sm = (m_busy != 0 && m_k >= TS + 1 && m_k <= TS + TT) ? 0 : 1;
      e_sg = (m_busy != 0 && m_disp != 0 && m_k >= L + TS + 1 && m_k <= L + TS + TT) ? 0 : 1;
      chk("sm_n", int'(sm_n), e_sm);
      chk("sg_n", int'(sg_n), e_sg);
      chk("st_n", int'(st_n), m_st);
      chk("r_wi", int'(r_wi), m_rw);
      chk("adr", int'(adr), m_adr);
      chk("cyc_type", int'(cyc_type), m_ct);
      chk("disp_ack", int'(disp_ack), m_ack);
      chk("cpu_done", int'(cpu_done), m_done);
      chk("strobe_overlap", int'(!sm_n && !sg_n), 0);
   end

   // Observe one granted cycle; scramble request inputs mid-cycle; release request at its end.
   task automatic watch(input int ct_exp, input int a_exp, input int st_exp, input int rw_exp,
                        output int sm_first, output int sm_cnt, output int sg_first,
                        output int sg_cnt, output int end_at, output int bad);
      int j;
      j = 0; sm_first = 0; sm_cnt = 0; sg_first = 0; sg_cnt = 0; end_at = 0; bad = 0;
      for (int c = 0; c < 60 && end_at == 0; c++) begin
         @(negedge clk);
         if (j == 0 && cyc_type != 2'd0) j = 1;
         else if (j > 0)                 j++;
         if (j > 0) begin
            if (j == 4) begin
               disp_slice = ~disp_slice;
               cpu_slice  = ~cpu_slice;
               cpu_rd     = ~cpu_rd;
            end
            if (!sm_n) begin sm_cnt++; if (sm_first == 0) sm_first = j; end
            if (!sg_n) begin sg_cnt++; if (sg_first == 0) sg_first = j; end
            if (disp_ack || cpu_done) begin
               end_at   = j;
               disp_req = 1'b0;
               ve_n     = 1'b1;
            end else if (int'(cyc_type) != ct_exp || int'(adr) != a_exp ||
                         int'(st_n) != st_exp || int'(r_wi) != rw_exp) begin
               bad++;
            end
         end
      end
   endtask

   initial begin
      int smf, smc, sgf, sgc, ea, bad;
      int seq[8];
      int exp_seq[8];
      int ng, ndone, acks_between, prev_ct, got_sm;
      exp_seq = '{1, 1, 1, 2, 1, 1, 1, 2};

      // Reset values
      @(negedge clk);
      chk("rst_sm", int'(sm_n), 1);
      chk("rst_sg", int'(sg_n), 1);
      chk("rst_st", int'(st_n), 1);
      chk("rst_rw", int'(r_wi), 1);
      chk("rst_adr", int'(adr), 0);
      chk("rst_cyc", int'(cyc_type), 0);

      // Display cycle, slice 5
      reset_n = 1'b1; disp_req = 1'b1; disp_slice = 4'd5;
      watch(1, 5, 1, 1, smf, smc, sgf, sgc, ea, bad);
      chk("disp_sm_first", smf, 3);
      chk("disp_sm_cnt", smc, 4);
      chk("disp_sg_first", sgf, 11);
      chk("disp_sg_cnt", sgc, 4);
      chk("disp_ack_at", ea, 17);
      chk("disp_frozen", bad, 0);
      @(negedge clk);
      chk("disp_ack_width", int'(disp_ack), 0);

      // CPU read, slice 9
      ve_n = 1'b0; cpu_rd = 1'b1; cpu_slice = 4'd9;
      watch(3, 9, 0, 1, smf, smc, sgf, sgc, ea, bad);
      chk("rd_sm_first", smf, 3);
      chk("rd_sm_cnt", smc, 4);
      chk("rd_sg_cnt", sgc, 0);
      chk("rd_done_at", ea, 9);
      chk("rd_frozen", bad, 0);
      @(negedge clk);
      chk("rd_done_width", int'(cpu_done), 0);

      // CPU write, slice 3
      ve_n = 1'b0; cpu_rd = 1'b0; cpu_slice = 4'd3;
      watch(2, 3, 0, 0, smf, smc, sgf, sgc, ea, bad);
      chk("wr_done_at", ea, 9);
      chk("wr_frozen", bad, 0);
      chk("wr_sg_cnt", sgc, 0);

      // Starvation: both held continuously
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1; disp_req = 1'b1; ve_n = 1'b0; cpu_rd = 1'b0;
      ng = 0; ndone = 0; acks_between = 0; prev_ct = 0;
      for (int c = 0; c < 300 && ndone < 2; c++) begin
         @(negedge clk);
         if (prev_ct == 0 && cyc_type != 2'd0 && ng < 8) begin
            seq[ng] = int'(cyc_type);
            ng++;
         end
         prev_ct = int'(cyc_type);
         if (disp_ack && ndone == 1) acks_between++;
         if (cpu_done) ndone++;
      end
      chk("starve_grants", ng, 8);
      for (int i = 0; i < 8; i++) chk($sformatf("starve_seq%0d", i), (i < ng) ? seq[i] : -1, exp_seq[i]);
      chk("starve_acks_between", acks_between, 3);

      // Reset during STROBE of a display cycle
      disp_req = 1'b0; ve_n = 1'b1; reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1; disp_req = 1'b1; disp_slice = 4'd7;
      got_sm = 0;
      for (int c = 0; c < 30 && got_sm == 0; c++) begin
         @(negedge clk);
         if (!sm_n) got_sm = 1;
      end
      chk("abort_reached_strobe", got_sm, 1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_sm", int'(sm_n), 1);
      chk("abort_sg", int'(sg_n), 1);
      chk("abort_cyc", int'(cyc_type), 0);
      chk("abort_ack", int'(disp_ack), 0);
      reset_n = 1'b1;
      watch(1, 7, 1, 1, smf, smc, sgf, sgc, ea, bad);
      chk("regrant_ack_at", ea, 17);
      chk("regrant_frozen", bad, 0);

      // Randomized traffic: protocol-following first half, unconstrained second half
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         disp_slice = 4'($urandom);
         cpu_slice  = 4'($urandom);
         cpu_rd     = 1'($urandom);
         if (i < 1500) begin
            if (disp_ack)       disp_req = ($urandom_range(0, 2) == 0);
            else if (!disp_req) disp_req = ($urandom_range(0, 3) == 0);
            if (cpu_done)       ve_n = 1'b1;
            else if (ve_n)      ve_n = !($urandom_range(0, 4) == 0);
         end else begin
            disp_req = 1'($urandom);
            ve_n     = 1'($urandom);
         end
         reset_n = !($urandom_range(0, 299) == 0);
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
